// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_pkg
//  Description : Shared definitions for the instruction-decode stage:
//                RV opcode values, instruction field bit positions, the
//                decoded-instruction struct and small opcode classifiers.
//  Config      : ID_SCOREBOARD_EN (used by id_stage; the classifiers here
//                are only referenced when it is defined)
//  Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_32  = 7'b0111011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // Field LSB positions inside the 32-bit instruction word
    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    // Register fields are kept at full 5-bit width here; users truncate
    // them to the configured register-address width.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } dec_t;

    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t d;
        d.opcode = instr[OPCODE_LSB +: 7];
        d.rd     = instr[RD_LSB     +: 5];
        d.rs1    = instr[RS1_LSB    +: 5];
        d.rs2    = instr[RS2_LSB    +: 5];
        d.funct3 = instr[FUNCT3_LSB +: 3];
        d.funct7 = instr[FUNCT7_LSB +: 7];
        return d;
    endfunction

    // Opcodes whose rs1 field is a real source operand
    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == LUI) || (op == AUIPC) || (op == JAL));
    endfunction

    // Opcodes whose rs2 field is a real source operand
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP) || (op == OP_32) || (op == STORE) || (op == BRANCH);
    endfunction

    // Opcodes that produce a register result
    function automatic logic writes_rd(input logic [6:0] op);
        return !((op == STORE) || (op == BRANCH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_if
//  Description : Bundle of fetch-side handshake, write-back port and the
//                ID/EX pipeline-register outputs of the decode stage.
//                master : fetch/write-back/execute side (drives in_*, wb_*,
//                         out_ready)
//                slave  : the decode stage itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_stage_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;

    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_opcode;
    logic [AW-1:0]   out_rd;
    logic [AW-1:0]   out_rs1;
    logic [AW-1:0]   out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_rdata1;
    logic [XLEN-1:0] out_rdata2;

    modport master (
        output in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_rdata1, out_rdata2
    );

    modport slave (
        input  in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_rdata1, out_rdata2
    );

endinterface
`default_nettype wire

// File: rtl/id_stage_regfile_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_bypass
//  Description : NREGS x XLEN register file, two combinational read ports,
//                one write port. x0 reads as zero and ignores writes. A
//                write in progress is forwarded to a matching read port in
//                the same cycle. Synchronous reset clears every register
//                and suppresses the write that cycle.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                i_we/i_waddr/i_wdata - write port
//                i_raddr1/i_raddr2  - read addresses
//                o_rdata1/o_rdata2  - read data (bypassed)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_bypass #(
    parameter  int XLEN  = 64,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_we,
    input  wire logic [AW-1:0]   i_waddr,
    input  wire logic [XLEN-1:0] i_wdata,
    input  wire logic [AW-1:0]   i_raddr1,
    input  wire logic [AW-1:0]   i_raddr2,
    output logic      [XLEN-1:0] o_rdata1,
    output logic      [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
        if (a == '0) begin
            return '0;
        end else if (i_we && (i_waddr == a)) begin
            return i_wdata;
        end else begin
            return r_mem[a];
        end
    endfunction

    always_comb begin
        o_rdata1 = rd_port(i_raddr1);
        o_rdata2 = rd_port(i_raddr2);
    end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction decode stage. Splits the incoming instruction
//                into fields, reads both source operands from the internal
//                register file (with write-back bypass) and holds the result
//                in an ID/EX pipeline register behind a valid/ready
//                handshake. While the output is held, operands keep
//                tracking write-backs to the held source registers.
//  Ports       : Clk, Reset - clock, synchronous active-high reset
//                bus        - id_stage_if.slave (fetch handshake, write-back,
//                             decoded outputs)
//  Config      : ID_SCOREBOARD_EN - per-register busy bits; the stage stalls
//                fetch while a needed source register has a write pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input wire logic Clk,
    input wire logic Reset,
    id_stage_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    // ---------------------------------------------------------------- decode
    dec_t            w_dec;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;

    assign w_dec = decode_instr(bus.in_instr);
    assign w_rs1 = w_dec.rs1[AW-1:0];
    assign w_rs2 = w_dec.rs2[AW-1:0];

    regfile_bypass #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (Clk),
        .rst      (Reset),
        .i_we     (bus.wb_en),
        .i_waddr  (bus.wb_rd),
        .i_wdata  (bus.wb_data),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    // ------------------------------------------------------ pipeline register
    dec_t            r_dec;
    logic            r_valid;
    logic [XLEN-1:0] r_rdata1;
    logic [XLEN-1:0] r_rdata2;
    logic [AW-1:0]   w_held_rd;
    logic [AW-1:0]   w_held_rs1;
    logic [AW-1:0]   w_held_rs2;
    logic            w_stall;
    logic            w_capture;
    logic            w_hold;

    assign w_held_rd  = r_dec.rd[AW-1:0];
    assign w_held_rs1 = r_dec.rs1[AW-1:0];
    assign w_held_rs2 = r_dec.rs2[AW-1:0];

    assign bus.in_ready = !Reset && (!r_valid || bus.out_ready) && !w_stall;
    assign w_capture    = bus.in_valid && bus.in_ready;
    assign w_hold       = r_valid && !bus.out_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid  <= 1'b0;
            r_dec    <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else if (w_capture) begin
            r_valid  <= 1'b1;
            r_dec    <= w_dec;
            r_rdata1 <= w_rdata1;
            r_rdata2 <= w_rdata2;
        end else if (w_hold) begin
            // Fields frozen; operands snoop write-backs so the value handed
            // to execute is never older than the register file.
            if (bus.wb_en && (bus.wb_rd == w_held_rs1) && (w_held_rs1 != '0)) begin
                r_rdata1 <= bus.wb_data;
            end
            if (bus.wb_en && (bus.wb_rd == w_held_rs2) && (w_held_rs2 != '0)) begin
                r_rdata2 <= bus.wb_data;
            end
        end else begin
            // Drained (or idle): nothing new captured this cycle
            r_valid <= 1'b0;
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.out_opcode = r_dec.opcode;
    assign bus.out_rd     = w_held_rd;
    assign bus.out_rs1    = w_held_rs1;
    assign bus.out_rs2    = w_held_rs2;
    assign bus.out_funct3 = r_dec.funct3;
    assign bus.out_funct7 = r_dec.funct7;
    assign bus.out_rdata1 = r_rdata1;
    assign bus.out_rdata2 = r_rdata2;

    // ------------------------------------------------------------ scoreboard
`ifdef ID_SCOREBOARD_EN
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic             w_busy1;
    logic             w_busy2;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (r_valid && bus.out_ready && (w_held_rd != '0) && writes_rd(r_dec.opcode)) begin
            w_set[w_held_rd] = 1'b1;
        end
        if (bus.wb_en) begin
            w_clr[bus.wb_rd] = 1'b1;
        end
    end

    // Set takes priority over a same-cycle clear; bit 0 (x0) is never busy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & {{(NREGS-1){1'b1}}, 1'b0};
        end
    end

    // A source being written back this cycle is satisfied by the bypass.
    assign w_busy1 = r_busy[w_rs1] && !w_clr[w_rs1];
    assign w_busy2 = r_busy[w_rs2] && !w_clr[w_rs2];
    assign w_stall = (uses_rs1(w_dec.opcode) && w_busy1) ||
                     (uses_rs2(w_dec.opcode) && w_busy2);
`else
    assign w_stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Self-checking bench for id_stage. Directed instructions are
//                issued with hand-computed expected outputs pushed into a
//                queue; a monitor pops and compares on every output
//                transfer. Direct checks cover reset, handshake and hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    id_stage_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    id_stage #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] d1;
        logic [63:0] d2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [63:0] d1, input logic [63:0] d2);
        exp_t e;
        e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.f3 = f3; e.f7 = f7; e.d1 = d1; e.d2 = d2;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Offer one instruction; waits (bounded) for in_ready, then transfers.
    task automatic send(input logic [31:0] instr, input exp_t e, input bit push,
                        output int waits);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        waits = 0;
        #1;
        while (!bus.in_ready && waits < 20) begin
            tick();
            waits++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for instr %h, expected 1", instr);
        end else if (push) begin
            q.push_back(e);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [63:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = rd;
        bus.wb_data = data;
        tick();
        bus.wb_en   = 1'b0;
    endtask

    // Output monitor: a transfer happens at the next rising edge whenever
    // valid and ready are both high at the falling edge.
    always @(negedge Clk) begin : mon
        exp_t e;
        if (!Reset && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got opcode %h rd %0d, expected no output",
                         bus.out_opcode, bus.out_rd);
            end else begin
                e = q.pop_front();
                check("mon_opcode", 64'(bus.out_opcode), 64'(e.op));
                check("mon_rd",     64'(bus.out_rd),     64'(e.rd));
                check("mon_rs1",    64'(bus.out_rs1),    64'(e.rs1));
                check("mon_rs2",    64'(bus.out_rs2),    64'(e.rs2));
                check("mon_funct3", 64'(bus.out_funct3), 64'(e.f3));
                check("mon_funct7", 64'(bus.out_funct7), 64'(e.f7));
                check("mon_rdata1", bus.out_rdata1,      e.d1);
                check("mon_rdata2", bus.out_rdata2,      e.d2);
            end
        end
    end

    initial begin : stim
        int w;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b0;
        Reset         = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_rd",    64'(bus.out_rd),    64'd0);
        check("rst_rdata1",    bus.out_rdata1,     64'd0);
        Reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Write-back then add x7,x5,x6
        wb(5'd5, 64'h1234);
        send(32'h006283B3, mk(OPC_OP, 5'd7, 5'd5, 5'd6, 3'd0, 7'd0, 64'h1234, 64'd0), 1'b1, w);
        check("lat_out_valid", 64'(bus.out_valid), 64'd1);
        check("lat_out_rs1",   64'(bus.out_rs1),   64'd5);

        // Same-cycle bypass: addi x8,x5,3 while x5 <= 0xAA
        bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 64'hAA;
        send(32'h00328413, mk(OPC_OP_IMM, 5'd8, 5'd5, 5'd3, 3'd0, 7'd0, 64'hAA, 64'd0), 1'b1, w);
        bus.wb_en = 1'b0;

        // Back-to-back: sub x9,x5,x8 accepted with no wait
        send(32'h408284B3, mk(OPC_OP, 5'd9, 5'd5, 5'd8, 3'd0, 7'h20, 64'hAA, 64'd0), 1'b1, w);
        check("thru_no_wait", 64'(w), 64'd0);
        tick();
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);

        // Back-pressure: or x10,x5,x11 held 3 cycles, x11 <= 0x55 while held
        bus.out_ready = 1'b0;
        send(32'h00B2E533, mk(OPC_OP, 5'd10, 5'd5, 5'd11, 3'd6, 7'd0, 64'hAA, 64'h55), 1'b1, w);
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready", 64'(bus.in_ready),   64'd0);
            check("hold_rd",       64'(bus.out_rd),     64'd10);
            check("hold_funct3",   64'(bus.out_funct3), 64'd6);
            if (i == 1) begin
                bus.wb_en = 1'b1; bus.wb_rd = 5'd11; bus.wb_data = 64'h55;
            end
            tick();
            bus.wb_en = 1'b0;
        end
        check("snoop_rdata2", bus.out_rdata2,      64'h55);
        check("snoop_rdata1", bus.out_rdata1,      64'hAA);
        check("snoop_rs2",    64'(bus.out_rs2),    64'd11);
        bus.out_ready = 1'b1;
        tick();

        // x0: write ignored, both standalone and concurrent with the read
        wb(5'd0, 64'hFFFF);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 64'hFFFF;
        send(32'h00000633, mk(OPC_OP, 5'd12, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 64'd0), 1'b1, w);
        bus.wb_en = 1'b0;
        tick();

        // Reset while an instruction is held; concurrent write-back dropped
        bus.out_ready = 1'b0;
        send(32'h006286B3, mk(OPC_OP, 5'd13, 5'd5, 5'd6, 3'd0, 7'd0, 64'hAA, 64'd0), 1'b0, w);
        tick();
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        Reset = 1'b1;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 64'h77;
        tick();
        bus.wb_en = 1'b0;
        check("rst2_out_valid", 64'(bus.out_valid),  64'd0);
        check("rst2_out_rd",    64'(bus.out_rd),     64'd0);
        check("rst2_out_rs1",   64'(bus.out_rs1),    64'd0);
        check("rst2_opcode",    64'(bus.out_opcode), 64'd0);
        check("rst2_rdata1",    bus.out_rdata1,      64'd0);
        check("rst2_rdata2",    bus.out_rdata2,      64'd0);
        check("rst2_in_ready",  64'(bus.in_ready),   64'd0);
        Reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        // x5 must read 0: cleared by reset, 0x77 not written
        send(32'h006283B3, mk(OPC_OP, 5'd7, 5'd5, 5'd6, 3'd0, 7'd0, 64'd0, 64'd0), 1'b1, w);
        tick();

`ifdef ID_SCOREBOARD_EN
        // Writer of x3 issues, then addi x4,x3,1 must wait for x3 write-back
        send(32'h006281B3, mk(OPC_OP, 5'd3, 5'd5, 5'd6, 3'd0, 7'd0, 64'd0, 64'd0), 1'b1, w);
        tick();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00118213;
        #1;
        check("sb_stall0", 64'(bus.in_ready), 64'd0);
        tick();
        check("sb_stall1", 64'(bus.in_ready), 64'd0);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 64'h99;
        #1;
        check("sb_release", 64'(bus.in_ready), 64'd1);
        q.push_back(mk(OPC_OP_IMM, 5'd4, 5'd3, 5'd1, 3'd0, 7'd0, 64'h99, 64'd0));
        tick();
        bus.in_valid = 1'b0;
        bus.wb_en = 1'b0;
        // sw x3,0(x5): x3 free again, no stall
        send(32'h0032A023, mk(OPC_STORE, 5'd0, 5'd5, 5'd3, 3'd2, 7'd0, 64'd0, 64'h99), 1'b1, w);
        check("sb_sw_nostall", 64'(w), 64'd0);
        tick();
`endif

        repeat (3) tick();
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
